// File: rtl/msfsm_onehot_mealy_if.sv
// ---------------------------------------------------------------------------
// msfsm_onehot_mealy_if
// Bundles the signals one component FSM of an MSFSM decomposition exchanges
// with its environment: input triggers, transition-barrier lanes from peer
// FSMs, the hold request, and the FSM's place/fire/err/fire_cnt outputs.
//
// Parameters: NP places, NT transitions, NB barrier lanes per transition,
//             CNT_W firing-counter width.
// Signals:
//   trig     [NT-1:0]     per-transition input guard (level)
//   tb       [NT*NB-1:0]  barrier lanes, lane j of transition k at k*NB+j
//   hold                  freeze request
//   place    [NP-1:0]     place indicators
//   fire     [NT-1:0]     Mealy transition strobes
//   err                   sticky one-hot violation flag
//   fire_cnt [CNT_W-1:0]  count of cycles in which a transition fired
// Modports: master drives trig/tb/hold and observes the FSM outputs;
//           slave is the FSM itself.
// ---------------------------------------------------------------------------
interface msfsm_onehot_mealy_if #(
  parameter int NP    = 4,
  parameter int NT    = 5,
  parameter int NB    = 2,
  parameter int CNT_W = 8
) ();

  logic [NT-1:0]    trig;
  logic [NT*NB-1:0] tb;
  logic             hold;
  logic [NP-1:0]    place;
  logic [NT-1:0]    fire;
  logic             err;
  logic [CNT_W-1:0] fire_cnt;

  modport master (
    output trig, tb, hold,
    input  place, fire, err, fire_cnt
  );

  modport slave (
    input  trig, tb, hold,
    output place, fire, err, fire_cnt
  );

endinterface

// File: rtl/msfsm_onehot_mealy.sv
// ---------------------------------------------------------------------------
// msfsm_onehot_mealy
// One component FSM of a multiple-synchronised-FSM decomposition of a Petri
// net. Places are one-hot state bits; a transition fires when its source
// place is marked, its input trigger is high (unless it is a barrier-only
// transition) and every used barrier lane from the peer FSMs is high. The
// lowest-index enabled transition wins. Place indicators are exported so
// peers can build their own barriers.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    msfsm_onehot_mealy_if.slave (trig, tb, hold in;
//          place, fire, err, fire_cnt out)
// ---------------------------------------------------------------------------
module msfsm_onehot_mealy #(
  parameter int NP    = 4,
  parameter int NT    = 5,
  parameter int NB    = 2,
  parameter int INIT  = 0,
  parameter logic [NT*((NP > 1) ? $clog2(NP) : 1)-1:0] SRC = 10'b11_10_01_01_00,
  parameter logic [NT*((NP > 1) ? $clog2(NP) : 1)-1:0] DST = 10'b00_11_10_10_01,
  parameter logic [NT-1:0]    GUARD_EN = 5'b10111,
  parameter logic [NT*NB-1:0] TB_EN    = 10'h3FF,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  msfsm_onehot_mealy_if.slave bus
);

  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [NP-1:0] INIT_OH = NP'(1) << INIT;

  // Register intent, kept as an enum so the recovery decision reads clearly.
  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RECOVER = 2'd1,
    ST_RUN     = 2'd2
  } ctrl_e;

  logic [NP-1:0]    state_q, state_d;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             legal;
  logic [NT-1:0]    fireVec;
  logic             found;
  logic [PW-1:0]    srcK;
  logic [PW-1:0]    fireSrc;
  logic [PW-1:0]    fireDst;
  logic             guardOk;
  logic             barOk;
  ctrl_e            ctrl;

  // Legality check, transition enables with lowest-index priority, and the
  // resulting next state. A self-loop clears and re-sets the same bit, so the
  // state is unchanged while the strobe and counter still advance. Reset,
  // hold and an illegal state all suppress every strobe, which in turn keeps
  // state_d and cnt_d equal to their current values.
  always_comb begin
    legal   = (state_q != '0) && ((state_q & (state_q - NP'(1))) == '0);
    fireVec = '0;
    found   = 1'b0;
    srcK    = '0;
    fireSrc = '0;
    fireDst = '0;
    guardOk = 1'b0;
    barOk   = 1'b1;
    for (int k = 0; k < NT; k++) begin
      srcK    = SRC[k*PW +: PW];
      guardOk = bus.trig[k] | ~GUARD_EN[k];
      barOk   = 1'b1;
      for (int j = 0; j < NB; j++) begin
        // Unused lanes read as 1 so they never block the transition.
        barOk = barOk & (bus.tb[k*NB+j] | ~TB_EN[k*NB+j]);
      end
      if (!found && state_q[srcK] && guardOk && barOk) begin
        found      = 1'b1;
        fireVec[k] = 1'b1;
        fireSrc    = srcK;
        fireDst    = DST[k*PW +: PW];
      end
    end
    if (reset || bus.hold || !legal) begin
      fireVec = '0;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    if (|fireVec) begin
      state_d = (state_q & ~(NP'(1) << fireSrc)) | (NP'(1) << fireDst);
      cnt_d   = cnt_q + CNT_W'(1);
    end

    if (reset) begin
      ctrl = ST_RESET;
    end else if (!legal) begin
      ctrl = ST_RECOVER;
    end else begin
      ctrl = ST_RUN;
    end
  end

  // State, sticky error and firing counter. An illegal state jumps straight
  // back to INIT regardless of hold and latches err until the next reset; the
  // counter is left alone in that cycle because nothing fired.
  always_ff @(posedge clk) begin
    case (ctrl)
      ST_RESET: begin
        state_q <= INIT_OH;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end
      ST_RECOVER: begin
        state_q <= INIT_OH;
        err_q   <= 1'b1;
      end
      default: begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    endcase
  end

  // A non-one-hot state must not advertise any place to the peers.
  assign bus.place    = legal ? state_q : '0;
  assign bus.fire     = fireVec;
  assign bus.err      = err_q;
  assign bus.fire_cnt = cnt_q;

endmodule

// File: tb/tb_msfsm_onehot_mealy.sv
// ---------------------------------------------------------------------------
// tb_msfsm_onehot_mealy
// Drives the default 4-place / 5-transition FSM through directed scenarios
// and then random trigger/barrier/hold/reset traffic, comparing against a
// place-index reference model built from the Petri-net tables. A second
// instance (one self-loop transition, 2-bit counter) exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_msfsm_onehot_mealy;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  // Free-running clock; inputs change on the falling edge.
  always #5 clk = ~clk;

  msfsm_onehot_mealy_if #(.NP(4), .NT(5), .NB(2), .CNT_W(8)) bus ();
  msfsm_onehot_mealy_if #(.NP(4), .NT(1), .NB(2), .CNT_W(2)) bus2 ();

  msfsm_onehot_mealy #(
    .NP(4), .NT(5), .NB(2), .INIT(0),
    .SRC(10'b11_10_01_01_00), .DST(10'b00_11_10_10_01),
    .GUARD_EN(5'b10111), .TB_EN(10'h3FF), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  msfsm_onehot_mealy #(
    .NP(4), .NT(1), .NB(2), .INIT(0),
    .SRC(2'b00), .DST(2'b00),
    .GUARD_EN(1'b1), .TB_EN(2'b11), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the marked place as an index (-1 when corrupted).
  int mSrc   [5] = '{0, 1, 1, 2, 3};
  int mDst   [5] = '{1, 2, 2, 3, 0};
  bit mGuard [5] = '{1, 1, 1, 0, 1};
  int mPlace;
  bit mErr;
  int mCnt;
  logic [4:0] expFire;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] modelFire(input int p, input logic [4:0] t,
                                           input logic [9:0] b, input logic h,
                                           input logic r);
    if (r || h || p < 0) return 5'b0;
    for (int k = 0; k < 5; k++) begin
      if (mSrc[k] == p && (t[k] || !mGuard[k]) && b[2*k] && b[2*k+1])
        return 5'(1 << k);
    end
    return 5'b0;
  endfunction

  task automatic modelUpdate(input logic r, input logic [4:0] f);
    if (r) begin
      mPlace = 0; mErr = 1'b0; mCnt = 0;
    end else if (mPlace < 0) begin
      mPlace = 0; mErr = 1'b1;
    end else if (f != 5'b0) begin
      for (int k = 0; k < 5; k++)
        if (f[k]) mPlace = mDst[k];
      mCnt = (mCnt + 1) % 256;
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".fire"},  32'(bus.fire), 32'(expFire));
    check({tag, ".place"}, 32'(bus.place), (mPlace < 0) ? 32'd0 : (32'd1 << mPlace));
    check({tag, ".err"},   32'(bus.err), 32'(mErr));
    check({tag, ".cnt"},   32'(bus.fire_cnt), 32'(mCnt));
  endtask

  // Called at a falling edge: drive, compare, then advance one clock.
  task automatic applyStimulus(input string tag, input logic r, input logic [4:0] t,
                               input logic [9:0] b, input logic h);
    reset    = r;
    bus.trig = t;
    bus.tb   = b;
    bus.hold = h;
    expFire  = modelFire(mPlace, t, b, h, r);
    #1;
    checkOutput(tag);
    @(posedge clk);
    modelUpdate(r, expFire);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] lanes;
    reset     = 1'b1;
    reset2    = 1'b1;
    bus.trig  = '0;
    bus.tb    = '1;
    bus.hold  = 1'b0;
    bus2.trig = '0;
    bus2.tb   = '1;
    bus2.hold = 1'b0;
    mPlace = 0; mErr = 1'b0; mCnt = 0;
    @(negedge clk);
    @(negedge clk);

    // Reset held for two cycles.
    applyStimulus("rst0", 1'b1, 5'b0, 10'h3FF, 1'b0);
    applyStimulus("rst1", 1'b1, 5'b0, 10'h3FF, 1'b0);
    check("rst.place_const", 32'(bus.place), 32'h1);

    // Full cycle around the net; t3 is barrier-only.
    applyStimulus("cyc_t0", 1'b0, 5'b00001, 10'h3FF, 1'b0);
    applyStimulus("cyc_t1", 1'b0, 5'b00010, 10'h3FF, 1'b0);
    applyStimulus("cyc_t3", 1'b0, 5'b00000, 10'h3FF, 1'b0);
    applyStimulus("cyc_t4", 1'b0, 5'b10000, 10'h3FF, 1'b0);
    check("cyc.cnt_const", 32'(bus.fire_cnt), 32'd4);
    check("cyc.place_const", 32'(bus.place), 32'h1);

    // Priority, then a blocked barrier lane of t1 lets t2 win.
    applyStimulus("pri_t0", 1'b0, 5'b00001, 10'h3FF, 1'b0);
    applyStimulus("pri_t1", 1'b0, 5'b00110, 10'h3FF, 1'b0);
    applyStimulus("pri_t3", 1'b0, 5'b00000, 10'h3FF, 1'b0);
    applyStimulus("pri_t4", 1'b0, 5'b10000, 10'h3FF, 1'b0);
    applyStimulus("pri_t0b", 1'b0, 5'b00001, 10'h3FF, 1'b0);
    applyStimulus("bar_t2", 1'b0, 5'b00110, 10'h3F7, 1'b0);

    // Back to place 1, then hold for three cycles.
    applyStimulus("hb_t3", 1'b0, 5'b00000, 10'h3FF, 1'b0);
    applyStimulus("hb_t4", 1'b0, 5'b10000, 10'h3FF, 1'b0);
    applyStimulus("hb_t0", 1'b0, 5'b00001, 10'h3FF, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("hold", 1'b0, 5'b00010, 10'h3FF, 1'b1);
    applyStimulus("hold_rel", 1'b0, 5'b00010, 10'h3FF, 1'b0);

    // Corrupt the state to two marked places.
    reset    = 1'b0;
    bus.trig = 5'b00000;
    bus.tb   = 10'h3FF;
    bus.hold = 1'b0;
    force dut.state_q = 4'b0110;
    mPlace  = -1;
    expFire = 5'b0;
    #1;
    checkOutput("corrupt");
    release dut.state_q;
    @(posedge clk);
    modelUpdate(1'b0, expFire);
    @(negedge clk);
    check("recover.err_const", 32'(bus.err), 32'd1);
    applyStimulus("post_t0", 1'b0, 5'b00001, 10'h3FF, 1'b0);
    applyStimulus("post_t1", 1'b0, 5'b00010, 10'h3FF, 1'b0);
    applyStimulus("post_hold", 1'b0, 5'b00000, 10'h3FF, 1'b1);

    // Random traffic with occasional blocked lanes, holds and resets.
    for (int i = 0; i < 400; i++) begin
      rnd   = $urandom;
      lanes = ~($urandom & $urandom & $urandom);
      applyStimulus("rand", ($urandom_range(0, 31) == 0), rnd[4:0], lanes[9:0],
                    ($urandom_range(0, 7) == 0));
    end

    // Counter wrap on the single self-loop instance.
    @(negedge clk);
    reset2 = 1'b0;
    #1;
    check("wrap.rst_cnt", 32'(bus2.fire_cnt), 32'd0);
    bus2.trig = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("wrap.fire", 32'(bus2.fire), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("wrap.cnt", 32'(bus2.fire_cnt), 32'((i + 1) % 4));
      check("wrap.place", 32'(bus2.place), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
